uc_seq: RTL and testbench
=========================

Name: uc_seq

Overview:
- Sequencing control unit for the 8-bit single-cycle datapath.
- Consumes the instruction opcode field (instr[15:10]) and the registered zero flag, and drives the datapath controls s_inc, s_inm, we3, wez and op_alu, plus a new PC load enable (pc_en).
- Adds run/idle/halt/single-step sequencing, a retired-instruction counter and a sticky illegal-opcode flag.

Parameters:
- CNT_W, 16, width of retired-instruction counter.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous reset, active-low: reset=0 resets the block.
- start  input  1  one-cycle pulse; IDLE -> RUN.
- step_mode  input  1  1 = pause after each retired instruction.
- step  input  1  one-cycle pulse; PAUSE -> RUN for one instruction.
- opcode  input  6  instr[15:10] from program memory.
- z  input  1  registered zero flag from the datapath.
- s_inc  output  1  1 = PC+1, 0 = jump target instr[9:0].
- s_inm  output  1  1 = register-file write data is the immediate instr[11:4].
- we3  output  1  register-file write enable.
- wez  output  1  zero-flag load enable.
- op_alu  output  3  ALU operation select.
- pc_en  output  1  PC register load enable.
- halted  output  1  1 in HALT state.
- illegal  output  1  sticky; set on the first illegal opcode retired.
- instr_count  output  CNT_W  retired instructions, saturating.

Behaviour:
- States: IDLE, RUN, PAUSE, HALT. State and counters are registered; decode outputs are combinational from state+opcode+z (single-cycle).
- Reset (reset=0, async):
  - state=IDLE, illegal=0, instr_count=0, halted=0.
  - Reset mid-run aborts with no write on that edge.
- Outside RUN (IDLE/PAUSE/HALT), safe outputs:
  - pc_en=0, we3=0, wez=0, s_inc=1, s_inm=0, op_alu=000.
  - No counter change.
- IDLE -> RUN on start=1; otherwise stay.
- Decode in RUN (opcode[1:0] are operand bits where noted):
  - 1xxxxx ALU: op_alu=opcode[4:2], we3=1, wez=1, s_inm=0, s_inc=1.
  - 0000xx LI: we3=1, s_inm=1, wez=0, s_inc=1, op_alu=000.
  - 0001xx J: s_inc=0, no writes.
  - 0010xx JZ: s_inc=~z, no writes.
  - 0011xx JNZ: s_inc=z, no writes.
  - 0100xx NOP: s_inc=1, no writes.
  - 0111xx HALT: pc_en=0, no writes, next state=HALT; not counted.
  - 0101xx, 0110xx illegal: execute as NOP, set illegal=1 at clock edge.
- RUN, non-HALT opcode:
  - pc_en=1.
  - instr_count increments by 1, saturating at all-ones (no wrap).
  - Next state = PAUSE if step_mode=1, else RUN.
- PAUSE -> RUN on step=1; RUN then executes exactly one instruction before re-entering PAUSE, if step_mode is still 1. Clearing step_mode while in PAUSE has no effect until step=1.
- HALT:
  - halted=1; PC frozen on the HALT instruction.
  - start and step are ignored; only reset exits.
- Simultaneous events:
  - start and step both asserted in IDLE: start wins (-> RUN).
  - start asserted in RUN/PAUSE: ignored.
- Jump targets are taken from instr[9:0] by the datapath. The jump decision uses z as registered on the previous ALU instruction.

Test Plan:
- Reset low mid-RUN, release, no start for 5 cycles -> state IDLE, pc_en=0, we3=0, instr_count=0, illegal=0 throughout.
- start pulse; opcodes LI(000000), ALU 100100, NOP(010000) -> per cycle: (we3,s_inm)=(1,1); (we3,wez,op_alu)=(1,1,001); pc_en=1 every cycle; instr_count=3.
- RUN, z=1: JZ(001000) -> s_inc=0. z=0: JZ -> s_inc=1. JNZ(001100) with z=0 -> s_inc=0.
- HALT opcode (011100) -> pc_en=0 that cycle, halted=1 next cycle; start/step pulses ignored; instr_count unchanged.
- step_mode=1, start, then 3 step pulses spaced 4 cycles -> exactly 4 instructions retired (1 after start + 3 steps); pc_en high one cycle per retirement.
- Opcode 010100 -> no writes, s_inc=1, illegal=1 stays set. Preload near all-ones with CNT_W=2: 5 NOPs -> instr_count saturates at 3.

Source files
------------

// File: rtl/uc_seq_if.sv
// Control bundle between the sequencing control unit and the 8-bit datapath.
//   opcode : instr[15:10] from program memory (datapath -> control)
//   z      : registered zero flag (datapath -> control)
//   s_inc  : 1 = PC+1, 0 = jump target instr[9:0]
//   s_inm  : 1 = register-file write data is the immediate
//   we3    : register-file write enable
//   wez    : zero-flag load enable
//   op_alu : ALU operation select
//   pc_en  : PC register load enable
// master = control unit side, slave = datapath side.
interface uc_seq_if;
    localparam int unsigned OPC_W = 6;
    localparam int unsigned ALU_W = 3;

    logic [OPC_W-1:0] opcode;
    logic             z;
    logic             s_inc;
    logic             s_inm;
    logic             we3;
    logic             wez;
    logic [ALU_W-1:0] op_alu;
    logic             pc_en;

    modport master (
        input  opcode, z,
        output s_inc, s_inm, we3, wez, op_alu, pc_en
    );

    modport slave (
        output opcode, z,
        input  s_inc, s_inm, we3, wez, op_alu, pc_en
    );
endinterface

// File: rtl/uc_seq.sv
// Sequencing control unit for the 8-bit single-cycle datapath.
// Decodes the opcode into datapath controls while in RUN, and sequences
// IDLE/RUN/PAUSE/HALT with optional single-step. Keeps a saturating
// retired-instruction counter and a sticky illegal-opcode flag.
//   clk, reset   : clock, asynchronous active-low reset
//   start        : pulse, IDLE -> RUN
//   step_mode    : 1 = pause after every retired instruction
//   step         : pulse, PAUSE -> RUN for one instruction
//   dp           : datapath control bundle (uc_seq_if.master)
//   halted       : 1 while in HALT
//   illegal      : sticky, set when an illegal opcode retires
//   instr_count  : retired instructions, saturating
module uc_seq #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             step_mode,
    input  logic             step,
    uc_seq_if.master         dp,
    output logic             halted,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_count
);

    localparam int unsigned ALU_W = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        HALT  = 2'd3
    } state_t;

    state_t state_q;
    state_t state_d;
    logic   retire;
    logic   illegal_set;
    logic   halt_op;

    // Operand bits of the opcode field belong to the datapath, not to decode.
    logic   unused_operand;
    assign unused_operand = ^dp.opcode[1:0];

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and decode; defaults are the safe (non-RUN) outputs.
    always_comb begin
        state_d     = state_q;
        dp.pc_en    = 1'b0;
        dp.we3      = 1'b0;
        dp.wez      = 1'b0;
        dp.s_inc    = 1'b1;
        dp.s_inm    = 1'b0;
        dp.op_alu   = ALU_W'(0);
        retire      = 1'b0;
        illegal_set = 1'b0;
        halt_op     = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                end
            end
            PAUSE: begin
                if (step) begin
                    state_d = RUN;
                end
            end
            HALT: begin
                state_d = HALT;
            end
            RUN: begin
                if (dp.opcode[5]) begin
                    dp.op_alu = dp.opcode[4:2];
                    dp.we3    = 1'b1;
                    dp.wez    = 1'b1;
                end else begin
                    case (dp.opcode[4:2])
                        3'b000: begin
                            dp.we3   = 1'b1;
                            dp.s_inm = 1'b1;
                        end
                        3'b001:  dp.s_inc = 1'b0;
                        // z is the flag latched by the previous ALU instruction
                        3'b010:  dp.s_inc = ~dp.z;
                        3'b011:  dp.s_inc = dp.z;
                        3'b100:  dp.s_inc = 1'b1;
                        3'b101,
                        3'b110:  illegal_set = 1'b1;
                        default: halt_op = 1'b1;
                    endcase
                end

                // HALT keeps the PC on itself and does not retire.
                if (halt_op) begin
                    state_d = HALT;
                end else begin
                    dp.pc_en = 1'b1;
                    retire   = 1'b1;
                    state_d  = step_mode ? PAUSE : RUN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Sticky illegal flag and saturating retire counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            illegal     <= 1'b0;
            instr_count <= CNT_W'(0);
        end else begin
            if (illegal_set) begin
                illegal <= 1'b1;
            end
            if (retire && (instr_count != {CNT_W{1'b1}})) begin
                instr_count <= instr_count + CNT_W'(1);
            end
        end
    end

    assign halted = (state_q == HALT);

endmodule

// File: tb/tb_uc_seq.sv
// Bench for uc_seq: a 16-bit-counter instance and a 2-bit-counter instance
// run in lockstep on the same stimulus; expected control vectors are queued
// when a cycle is driven and popped when that cycle's outputs are sampled.
module tb_uc_seq;

    localparam logic [5:0] OP_LI   = 6'b000000;
    localparam logic [5:0] OP_J    = 6'b000100;
    localparam logic [5:0] OP_JZ   = 6'b001000;
    localparam logic [5:0] OP_JNZ  = 6'b001100;
    localparam logic [5:0] OP_NOP  = 6'b010000;
    localparam logic [5:0] OP_ILL1 = 6'b010100;
    localparam logic [5:0] OP_ILL2 = 6'b011000;
    localparam logic [5:0] OP_HALT = 6'b011100;
    localparam logic [5:0] OP_ADD  = 6'b100100;
    localparam logic [5:0] OP_ALU7 = 6'b111100;

    // Control vector {pc_en, we3, wez, s_inc, s_inm, op_alu[2:0]}
    localparam logic [7:0] C_SAFE = 8'b0001_0000;
    localparam logic [7:0] C_LI   = 8'b1101_1000;
    localparam logic [7:0] C_ALU1 = 8'b1111_0001;
    localparam logic [7:0] C_ALU7 = 8'b1111_0111;
    localparam logic [7:0] C_NOP  = 8'b1001_0000;
    localparam logic [7:0] C_JMP  = 8'b1000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        step_mode;
    logic        step;
    logic        halted;
    logic        illegal;
    logic [15:0] instr_count;
    logic        halted2;
    logic        illegal2;
    logic [1:0]  instr_count2;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    uc_seq_if dp ();
    uc_seq_if dp2 ();

    assign dp2.opcode = dp.opcode;
    assign dp2.z      = dp.z;

    logic [7:0] ctl;
    logic [7:0] ctl2;
    assign ctl  = {dp.pc_en, dp.we3, dp.wez, dp.s_inc, dp.s_inm, dp.op_alu};
    assign ctl2 = {dp2.pc_en, dp2.we3, dp2.wez, dp2.s_inc, dp2.s_inm, dp2.op_alu};

    uc_seq #(.CNT_W(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .step_mode   (step_mode),
        .step        (step),
        .dp          (dp),
        .halted      (halted),
        .illegal     (illegal),
        .instr_count (instr_count)
    );

    uc_seq #(.CNT_W(2)) dut2 (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .step_mode   (step_mode),
        .step        (step),
        .dp          (dp2),
        .halted      (halted2),
        .illegal     (illegal2),
        .instr_count (instr_count2)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1);
    end

    // Drive one cycle at the falling edge and queue its expected controls.
    task automatic apply(input logic [5:0] op, input logic zz, input logic [7:0] exp);
        @(negedge clk);
        start     = 1'b0;
        step      = 1'b0;
        dp.opcode = op;
        dp.z      = zz;
        exp_q.push_back(exp);
        #1;
    endtask

    // Start pulse from IDLE; opcode LI must not leak out while idle.
    task automatic kick();
        @(negedge clk);
        start     = 1'b1;
        step      = 1'b0;
        dp.opcode = OP_LI;
        dp.z      = 1'b0;
        #1;
        checks++;
        if (ctl !== C_SAFE) begin
            errors++;
            $display("FAIL kick_idle_ctl got=%b exp=%b", ctl, C_SAFE);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        step  = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        logic [5:0] ops[3]  = '{OP_NOP, OP_ILL1, OP_LI};
        logic [7:0] exps[3] = '{C_NOP, C_NOP, C_LI};
        logic [7:0] e;
        checks++;
        if (ctl !== C_SAFE || instr_count !== 16'd0 || illegal !== 1'b0 || halted !== 1'b0) begin
            errors++;
            $display("FAIL por_state ctl=%b cnt=%0d ill=%b hlt=%b", ctl, instr_count, illegal, halted);
        end
        @(negedge clk);
        reset = 1'b1;
        kick();
        for (int i = 0; i < 3; i++) begin
            apply(ops[i], 1'b0, exps[i]);
            e = exp_q.pop_front();
            checks++;
            if (ctl !== e) begin
                errors++;
                $display("FAIL reset_prerun_ctl[%0d] got=%b exp=%b", i, ctl, e);
            end
        end
        // Asynchronous reset in the middle of a RUN cycle.
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (ctl !== C_SAFE || instr_count !== 16'd0 || illegal !== 1'b0) begin
            errors++;
            $display("FAIL reset_async ctl=%b cnt=%0d ill=%b", ctl, instr_count, illegal);
        end
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            apply(OP_LI, 1'b0, C_SAFE);
            e = exp_q.pop_front();
            checks++;
            if (ctl !== e || instr_count !== 16'd0 || illegal !== 1'b0 || halted !== 1'b0) begin
                errors++;
                $display("FAIL reset_idle[%0d] ctl=%b exp=%b cnt=%0d ill=%b hlt=%b",
                         i, ctl, e, instr_count, illegal, halted);
            end
        end
    endtask

    task automatic test_basic();
        logic [5:0] ops[4]  = '{OP_LI, OP_ADD, OP_NOP, OP_HALT};
        logic [7:0] exps[4] = '{C_LI, C_ALU1, C_NOP, C_SAFE};
        logic [7:0] e;
        kick();
        for (int i = 0; i < 4; i++) begin
            apply(ops[i], 1'b0, exps[i]);
            e = exp_q.pop_front();
            checks++;
            if (ctl !== e) begin
                errors++;
                $display("FAIL basic_ctl[%0d] got=%b exp=%b", i, ctl, e);
            end
            checks++;
            if (instr_count !== 16'(i)) begin
                errors++;
                $display("FAIL basic_count[%0d] got=%0d exp=%0d", i, instr_count, i);
            end
        end
        do_reset();
    endtask

    task automatic test_jump();
        logic [5:0] ops[7]  = '{OP_JZ, OP_JZ, OP_JNZ, OP_JNZ, OP_J, OP_ALU7, OP_HALT};
        logic       zs[7]   = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [7:0] exps[7] = '{C_JMP, C_NOP, C_JMP, C_NOP, C_JMP, C_ALU7, C_SAFE};
        logic [7:0] e;
        kick();
        for (int i = 0; i < 7; i++) begin
            apply(ops[i], zs[i], exps[i]);
            e = exp_q.pop_front();
            checks++;
            if (ctl !== e || instr_count !== 16'(i)) begin
                errors++;
                $display("FAIL jump[%0d] ctl=%b exp=%b cnt=%0d exp_cnt=%0d", i, ctl, e, instr_count, i);
            end
        end
        do_reset();
    endtask

    task automatic test_halt();
        logic [7:0] e;
        kick();
        apply(OP_NOP, 1'b0, C_NOP);
        e = exp_q.pop_front();
        checks++;
        if (ctl !== e) begin
            errors++;
            $display("FAIL halt_pre_nop got=%b exp=%b", ctl, e);
        end
        apply(OP_HALT, 1'b0, C_SAFE);
        e = exp_q.pop_front();
        checks++;
        if (ctl !== e || halted !== 1'b0) begin
            errors++;
            $display("FAIL halt_decode ctl=%b exp=%b hlt=%b exp_hlt=0", ctl, e, halted);
        end
        // start/step pulses must not wake HALT.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            start     = (i % 2 == 0);
            step      = (i % 2 == 1);
            dp.opcode = OP_NOP;
            exp_q.push_back(C_SAFE);
            #1;
            e = exp_q.pop_front();
            checks++;
            if (ctl !== e || halted !== 1'b1 || instr_count !== 16'd1) begin
                errors++;
                $display("FAIL halt_hold[%0d] ctl=%b exp=%b hlt=%b cnt=%0d exp_cnt=1",
                         i, ctl, e, halted, instr_count);
            end
        end
        do_reset();
        #1;
        checks++;
        if (halted !== 1'b0 || instr_count !== 16'd0) begin
            errors++;
            $display("FAIL halt_exit_reset hlt=%b cnt=%0d", halted, instr_count);
        end
    endtask

    task automatic test_step();
        logic [7:0] e;
        int         pulses = 0;
        step_mode = 1'b1;
        kick();
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            dp.opcode = OP_NOP;
            step      = (c == 3 || c == 7 || c == 11);
            start     = (c == 5);
            exp_q.push_back((c % 4 == 0) ? C_NOP : C_SAFE);
            #1;
            e = exp_q.pop_front();
            if (ctl[7]) pulses++;
            checks++;
            if (ctl !== e) begin
                errors++;
                $display("FAIL step_ctl[%0d] got=%b exp=%b", c, ctl, e);
            end
        end
        checks++;
        if (pulses != 4 || instr_count !== 16'd4) begin
            errors++;
            $display("FAIL step_total pulses=%0d cnt=%0d exp=4", pulses, instr_count);
        end
        step_mode = 1'b0;
        do_reset();
    endtask

    task automatic test_illegal_sat();
        logic [5:0] ops[8]  = '{OP_ILL1, OP_ILL2, OP_NOP, OP_NOP, OP_NOP, OP_NOP, OP_NOP, OP_HALT};
        logic [7:0] e;
        logic [7:0] exp_ctl;
        logic [1:0] exp_c2;
        logic       exp_ill;
        kick();
        for (int i = 0; i < 8; i++) begin
            exp_ctl = (i == 7) ? C_SAFE : C_NOP;
            apply(ops[i], 1'b0, exp_ctl);
            e       = exp_q.pop_front();
            exp_c2  = (i > 3) ? 2'd3 : 2'(i);
            exp_ill = (i > 0);
            checks++;
            if (ctl !== e || ctl2 !== e) begin
                errors++;
                $display("FAIL ill_ctl[%0d] got=%b got2=%b exp=%b", i, ctl, ctl2, e);
            end
            checks++;
            if (instr_count !== 16'(i) || instr_count2 !== exp_c2) begin
                errors++;
                $display("FAIL sat_count[%0d] cnt=%0d exp=%0d cnt2=%0d exp2=%0d",
                         i, instr_count, i, instr_count2, exp_c2);
            end
            checks++;
            if (illegal !== exp_ill || illegal2 !== exp_ill) begin
                errors++;
                $display("FAIL ill_flag[%0d] got=%b got2=%b exp=%b", i, illegal, illegal2, exp_ill);
            end
        end
        @(negedge clk);
        checks++;
        if (halted2 !== 1'b1 || instr_count2 !== 2'd3 || instr_count !== 16'd7) begin
            errors++;
            $display("FAIL sat_final hlt2=%b cnt2=%0d exp2=3 cnt=%0d exp=7", halted2, instr_count2, instr_count);
        end
        do_reset();
    endtask

    initial begin
        reset     = 1'b0;
        start     = 1'b0;
        step      = 1'b0;
        step_mode = 1'b0;
        dp.opcode = OP_NOP;
        dp.z      = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        test_reset();
        test_basic();
        test_jump();
        test_halt();
        test_step();
        test_illegal_sat();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
